// File: rtl/cpu_pkg.sv
// Shared register-file indices, pair/op encodings and controller state type
// for the CPU register-pair controller.
package cpu_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_F = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  // Flag register low nibble is hardwired to zero.
  localparam logic [7:0] F_MASK_DEFAULT = 8'hF0;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AF = 2'd3
  } pair_sel_e;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } pair_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_DONE  = 3'd4
  } rpc_state_e;

  // High byte register of a pair. AF is the odd one out: A is the high byte.
  function automatic logic [2:0] pair_hi_idx(input pair_sel_e sel);
    logic [2:0] idx;
    case (sel)
      PAIR_BC: idx = REG_B;
      PAIR_DE: idx = REG_D;
      PAIR_HL: idx = REG_H;
      default: idx = REG_A;
    endcase
    return idx;
  endfunction

  // Low byte register of a pair.
  function automatic logic [2:0] pair_lo_idx(input pair_sel_e sel);
    logic [2:0] idx;
    case (sel)
      PAIR_BC: idx = REG_C;
      PAIR_DE: idx = REG_E;
      PAIR_HL: idx = REG_L;
      default: idx = REG_F;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pair_alu16.sv
// Combinational 16-bit pair arithmetic: pass-through (READ), LOAD, INC, DEC,
// with the F byte masked whenever the pair is AF.
module pair_alu16
  import cpu_pkg::*;
#(
  parameter logic [7:0] F_MASK = F_MASK_DEFAULT
) (
  input  pair_op_e    op_i,
  input  pair_sel_e   sel_i,
  input  logic [15:0] operand_i,
  input  logic [15:0] load_data_i,
  output logic [15:0] result_o
);

  logic [15:0] raw;

  // Select the raw 16-bit result, then apply the flag mask to F when targeted.
  always_comb begin
    raw = operand_i;
    case (op_i)
      OP_READ: raw = operand_i;
      OP_LOAD: raw = load_data_i;
      OP_INC:  raw = operand_i + 16'd1;
      OP_DEC:  raw = operand_i - 16'd1;
      default: raw = operand_i;
    endcase
    result_o = raw;
    if (sel_i == PAIR_AF) begin
      result_o[7:0] = raw[7:0] & F_MASK;
    end
  end

endmodule

// File: rtl/reg_pair_ctrl.sv
// Register-file port owner: passes core byte accesses through while idle and
// sequences 16-bit pair operations (read both bytes, then write low, then high)
// over the single write port, stalling the core meanwhile.
module reg_pair_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] F_MASK = F_MASK_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_core_a_sel,
  input  logic [2:0]  i_core_b_sel,
  input  logic        i_core_wr_en,
  input  logic [2:0]  i_core_wr_sel,
  input  logic [7:0]  i_core_wr_data,
  output logic        o_core_stall,
  input  logic        i_pair_req,
  input  logic [1:0]  i_pair_sel,
  input  logic [1:0]  i_pair_op,
  input  logic [15:0] i_pair_data,
  output logic        o_pair_busy,
  output logic        o_pair_done,
  output logic [15:0] o_pair_result,
  output logic [2:0]  o_rf_a_sel,
  output logic [2:0]  o_rf_b_sel,
  output logic        o_rf_wr_en,
  output logic [2:0]  o_rf_wr_sel,
  output logic [7:0]  o_rf_wr_data,
  input  logic [7:0]  i_rf_a,
  input  logic [7:0]  i_rf_b
);

  // state  | meaning
  // IDLE   | core owns the rf ports; a pending pair request is accepted
  // RD     | both bytes of the pair presented on read ports A(hi)/B(lo)
  // WR_LO  | low byte of the result written
  // WR_HI  | high byte of the result written
  // DONE   | one-cycle completion pulse, no write

  rpc_state_e  state_q, state_d;
  pair_sel_e   sel_q;
  pair_op_e    op_q;
  logic [15:0] data_q;
  logic [15:0] result_q;
  logic [15:0] alu_result;
  logic [2:0]  hi_idx, lo_idx;
  logic        accept;

  assign hi_idx = pair_hi_idx(sel_q);
  assign lo_idx = pair_lo_idx(sel_q);
  assign accept = (state_q == ST_IDLE) && i_pair_req;

  pair_alu16 #(.F_MASK(F_MASK)) u_alu (
    .op_i        (op_q),
    .sel_i       (sel_q),
    .operand_i   ({i_rf_a, i_rf_b}),
    .load_data_i (data_q),
    .result_o    (alu_result)
  );

  // State register plus operand latch at accept and result capture in RD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= PAIR_BC;
      op_q     <= OP_READ;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q  <= pair_sel_e'(i_pair_sel);
        op_q   <= pair_op_e'(i_pair_op);
        data_q <= i_pair_data;
      end
      if (state_q == ST_RD) begin
        result_q <= alu_result;
      end
    end
  end

  // Next-state and rf port muxing; core passes through only while idle.
  always_comb begin
    state_d      = state_q;
    o_core_stall = 1'b1;
    o_pair_done  = 1'b0;
    o_rf_a_sel   = hi_idx;
    o_rf_b_sel   = lo_idx;
    o_rf_wr_en   = 1'b0;
    o_rf_wr_sel  = lo_idx;
    o_rf_wr_data = result_q[7:0];
    case (state_q)
      ST_IDLE: begin
        o_core_stall = 1'b0;
        o_rf_a_sel   = i_core_a_sel;
        o_rf_b_sel   = i_core_b_sel;
        o_rf_wr_en   = i_core_wr_en;
        o_rf_wr_sel  = i_core_wr_sel;
        o_rf_wr_data = (i_core_wr_sel == REG_F) ? (i_core_wr_data & F_MASK)
                                                : i_core_wr_data;
        if (i_pair_req) state_d = ST_RD;
      end
      ST_RD: begin
        state_d = (op_q == OP_READ) ? ST_DONE : ST_WR_LO;
      end
      ST_WR_LO: begin
        o_rf_wr_en = 1'b1;
        state_d    = ST_WR_HI;
      end
      ST_WR_HI: begin
        o_rf_wr_en   = 1'b1;
        o_rf_wr_sel  = hi_idx;
        o_rf_wr_data = result_q[15:8];
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        o_pair_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_pair_busy   = o_core_stall;
  assign o_pair_result = result_q;

endmodule

// File: tb/tb_reg_pair_ctrl.sv
// Bench for reg_pair_ctrl: an 8x8 register file model hangs off the rf ports,
// a separate reference register image predicts every pair op result.
module tb_reg_pair_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [2:0]  i_core_a_sel, i_core_b_sel, i_core_wr_sel;
  logic        i_core_wr_en;
  logic [7:0]  i_core_wr_data;
  logic        o_core_stall;
  logic        i_pair_req;
  logic [1:0]  i_pair_sel, i_pair_op;
  logic [15:0] i_pair_data;
  logic        o_pair_busy, o_pair_done;
  logic [15:0] o_pair_result;
  logic [2:0]  o_rf_a_sel, o_rf_b_sel, o_rf_wr_sel;
  logic        o_rf_wr_en;
  logic [7:0]  o_rf_wr_data;
  logic [7:0]  i_rf_a, i_rf_b;

  logic [7:0]  rf [8];
  logic [7:0]  ref_rf [8];
  logic [2:0]  log_sel [$];
  logic [7:0]  log_data [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          hi_tab [4] = '{0, 2, 4, 7};
  int          lo_tab [4] = '{1, 3, 5, 6};

  reg_pair_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_core_a_sel   (i_core_a_sel),
    .i_core_b_sel   (i_core_b_sel),
    .i_core_wr_en   (i_core_wr_en),
    .i_core_wr_sel  (i_core_wr_sel),
    .i_core_wr_data (i_core_wr_data),
    .o_core_stall   (o_core_stall),
    .i_pair_req     (i_pair_req),
    .i_pair_sel     (i_pair_sel),
    .i_pair_op      (i_pair_op),
    .i_pair_data    (i_pair_data),
    .o_pair_busy    (o_pair_busy),
    .o_pair_done    (o_pair_done),
    .o_pair_result  (o_pair_result),
    .o_rf_a_sel     (o_rf_a_sel),
    .o_rf_b_sel     (o_rf_b_sel),
    .o_rf_wr_en     (o_rf_wr_en),
    .o_rf_wr_sel    (o_rf_wr_sel),
    .o_rf_wr_data   (o_rf_wr_data),
    .i_rf_a         (i_rf_a),
    .i_rf_b         (i_rf_b)
  );

  always #5 i_clk = ~i_clk;

  // Register file: async read, single synchronous write port; writes are logged.
  assign i_rf_a = rf[o_rf_a_sel];
  assign i_rf_b = rf[o_rf_b_sel];
  always @(posedge i_clk) begin
    if (o_rf_wr_en) begin
      rf[o_rf_wr_sel] <= o_rf_wr_data;
      log_sel.push_back(o_rf_wr_sel);
      log_data.push_back(o_rf_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f_filter(input int idx, input logic [7:0] d);
    return (idx == 6) ? (d & 8'hF0) : d;
  endfunction

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("%s rf[%0d]", tag, i), {24'd0, rf[i]}, {24'd0, ref_rf[i]});
    end
  endtask

  // Core byte write while the controller is idle.
  task automatic core_write(input int idx, input logic [7:0] d);
    @(negedge i_clk);
    i_core_wr_en   = 1'b1;
    i_core_wr_sel  = idx[2:0];
    i_core_wr_data = d;
    @(negedge i_clk);
    i_core_wr_en = 1'b0;
    ref_rf[idx] = f_filter(idx, d);
  endtask

  // One pair op; optional core write in the accept cycle, optional core noise
  // while the op is in flight (must be ignored).
  task automatic pair_op(input int sel, input int op, input logic [15:0] d,
                         input bit cw, input int cw_sel, input logic [7:0] cw_d,
                         input bit noise);
    int hi, lo, edges, nwr;
    logic [15:0] v, exp_res;
    hi = hi_tab[sel];
    lo = lo_tab[sel];
    @(negedge i_clk);
    i_pair_req     = 1'b1;
    i_pair_sel     = sel[1:0];
    i_pair_op      = op[1:0];
    i_pair_data    = d;
    i_core_wr_en   = cw;
    i_core_wr_sel  = cw_sel[2:0];
    i_core_wr_data = cw_d;
    @(posedge i_clk);
    #1;
    log_sel.delete();
    log_data.delete();
    if (cw) ref_rf[cw_sel] = f_filter(cw_sel, cw_d);
    v = {ref_rf[hi], ref_rf[lo]};
    case (op)
      0:       exp_res = v;
      1:       exp_res = d;
      2:       exp_res = v + 16'd1;
      default: exp_res = v - 16'd1;
    endcase
    if (sel == 3) exp_res[7:0] = exp_res[7:0] & 8'hF0;
    check_val("stall_busy", {30'd0, o_core_stall, o_pair_busy}, 32'd3);
    i_pair_sel     = 2'($urandom);
    i_pair_op      = 2'($urandom);
    i_pair_data    = 16'($urandom);
    i_core_wr_en   = noise;
    i_core_wr_sel  = 3'($urandom);
    i_core_wr_data = 8'($urandom);
    i_core_a_sel   = 3'($urandom);
    i_core_b_sel   = 3'($urandom);
    edges = 0;
    while (!o_pair_done && edges < 20) begin
      @(posedge i_clk);
      #1;
      edges++;
    end
    check_val("done_seen", {31'd0, o_pair_done}, 32'd1);
    check_val("latency", edges, (op == 0) ? 1 : 3);
    check_val("result", {16'd0, o_pair_result}, {16'd0, exp_res});
    // Request still high through DONE must not start a second op.
    @(posedge i_clk);
    #1;
    check_val("done_pulse_1cyc", {31'd0, o_pair_done}, 32'd0);
    check_val("idle_after_done", {31'd0, o_pair_busy}, 32'd0);
    check_val("result_held", {16'd0, o_pair_result}, {16'd0, exp_res});
    i_pair_req   = 1'b0;
    i_core_wr_en = 1'b0;
    nwr = log_sel.size();
    check_val("write_count", nwr, (op == 0) ? 0 : 2);
    if (op != 0) begin
      ref_rf[lo] = exp_res[7:0];
      ref_rf[hi] = exp_res[15:8];
      if (nwr == 2) begin
        check_val("wr_lo_sel", {29'd0, log_sel[0]}, lo);
        check_val("wr_lo_data", {24'd0, log_data[0]}, {24'd0, exp_res[7:0]});
        check_val("wr_hi_sel", {29'd0, log_sel[1]}, hi);
        check_val("wr_hi_data", {24'd0, log_data[1]}, {24'd0, exp_res[15:8]});
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_core_a_sel = '0; i_core_b_sel = '0; i_core_wr_en = 1'b0;
    i_core_wr_sel = '0; i_core_wr_data = '0;
    i_pair_req = 1'b0; i_pair_sel = '0; i_pair_op = '0; i_pair_data = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    check_val("rst_stall", {31'd0, o_core_stall}, 32'd0);
    check_val("rst_busy", {31'd0, o_pair_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_pair_done}, 32'd0);
    check_val("rst_result", {16'd0, o_pair_result}, 32'd0);
    check_val("rst_wr_en", {31'd0, o_rf_wr_en}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 8; i++) core_write(i, 8'($urandom));
    check_rf("seed");

    pair_op(0, 1, 16'h1234, 0, 0, 8'h00, 0);
    check_rf("load_bc");

    core_write(4, 8'hFF); core_write(5, 8'hFF);
    pair_op(2, 2, 16'h0000, 0, 0, 8'h00, 0);
    check_rf("inc_hl_wrap");

    core_write(2, 8'h00); core_write(3, 8'h00);
    pair_op(1, 3, 16'h0000, 0, 0, 8'h00, 0);
    check_rf("dec_de_wrap");

    pair_op(3, 1, 16'hABCD, 0, 0, 8'h00, 0);
    check_rf("load_af");

    core_write(6, 8'hFF);
    check_val("core_f_mask", {24'd0, rf[6]}, 32'hF0);

    core_write(4, 8'hBE); core_write(5, 8'hEF);
    pair_op(2, 0, 16'h0000, 0, 0, 8'h00, 0);
    check_rf("read_hl");

    core_write(0, 8'h54); core_write(1, 8'h00);
    pair_op(0, 2, 16'h0000, 1, 0, 8'h55, 1);
    check_rf("inc_bc_core_wr");

    // Reset during WR_HI of LOAD DE: low byte stays, high byte never written.
    core_write(2, 8'h00); core_write(3, 8'h00);
    @(negedge i_clk);
    i_pair_req = 1'b1; i_pair_sel = 2'd1; i_pair_op = 2'd1; i_pair_data = 16'hA1B2;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check_val("abort_wr_en", {31'd0, o_rf_wr_en}, 32'd0);
    check_val("abort_stall", {31'd0, o_core_stall}, 32'd0);
    check_val("abort_done", {31'd0, o_pair_done}, 32'd0);
    i_pair_req = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    ref_rf[3] = 8'hB2;
    check_rf("abort_de");

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 2) == 0) core_write($urandom_range(0, 7), 8'($urandom));
      pair_op($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
              1'($urandom), $urandom_range(0, 7), 8'($urandom), 1'($urandom));
    end
    check_rf("random_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
